// File: rtl/exp_pulse_gen.sv
// Exponential pulse generator: linear rise to the programmed amplitude, then
// geometric decay, periodically retriggered, streamed as AXI-Stream samples.
module exp_pulse_gen #(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int COEF_FRAC        = 16
) (
  input  logic                               clk,
  input  logic                               aresetn,
  input  logic                               enable,
  input  logic signed [AXIS_TDATA_WIDTH-1:0] amplitude,
  input  logic signed [AXIS_TDATA_WIDTH-1:0] baseline,
  input  logic [3:0]                         rise_shift,
  input  logic [15:0]                        decay_coef,
  input  logic [29:0]                        period,
  output logic signed [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               pulse_start,
  output logic                               busy
);

  localparam int W = AXIS_TDATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RISE, DECAY} state_t;

  state_t                state_q, state_d;
  logic signed [W-1:0]   env_q, env_d;
  logic signed [W-1:0]   tdata_q, tdata_d;
  logic [29:0]           cnt_q, cnt_d;
  logic [15:0]           ridx_q, ridx_d;
  logic signed [W-1:0]   amp_q, amp_d;
  logic signed [W-1:0]   base_q, base_d;
  logic [3:0]            rs_q, rs_d;
  logic [15:0]           coef_q, coef_d;
  logic [29:0]           per_q, per_d;
  logic                  xfer;
  logic                  new_pulse;

  function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
    logic signed [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1])
      return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return s[W-1:0];
  endfunction

  // Coefficient is zero-extended so 0xFFFF stays just below unity; the
  // arithmetic shift floors, so negative tails settle at -1 rather than 0.
  function automatic logic signed [W-1:0] decay_mul(input logic signed [W-1:0] e,
                                                    input logic [15:0] c);
    logic signed [W+17:0] p;
    logic signed [W+17:0] sh;
    p  = $signed({e[W-1], e}) * $signed({1'b0, c});
    sh = p >>> COEF_FRAC;
    return sh[W-1:0];
  endfunction

  assign xfer = m_axis_tvalid && m_axis_tready;

  always_comb begin
    state_d   = state_q;
    env_d     = env_q;
    tdata_d   = tdata_q;
    cnt_d     = cnt_q;
    ridx_d    = ridx_q;
    amp_d     = amp_q;
    base_d    = base_q;
    rs_d      = rs_q;
    coef_d    = coef_q;
    per_d     = per_q;
    new_pulse = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          new_pulse = 1'b1;
          cnt_d     = '0;
        end
      end
      default: begin
        if (xfer) begin
          if (!enable) begin
            state_d = IDLE;
            env_d   = '0;
            tdata_d = '0;
            cnt_d   = '0;
            ridx_d  = '0;
          end else if (per_q != '0 && cnt_q == per_q - 30'd1) begin
            new_pulse = 1'b1;
            cnt_d     = '0;
          end else begin
            // One-shot mode parks the counter instead of wrapping back to 0.
            if (per_q != '0 || cnt_q != '1)
              cnt_d = cnt_q + 30'd1;
            if (state_q == RISE && ({1'b0, ridx_q} + 17'd1) < (17'd1 << rs_q)) begin
              ridx_d = ridx_q + 16'd1;
              env_d  = sat_add(env_q, amp_q >>> rs_q);
            end else begin
              state_d = DECAY;
              env_d   = decay_mul(env_q, coef_q);
            end
            tdata_d = sat_add(base_q, env_d);
          end
        end
      end
    endcase

    // New pulse builds on the current envelope (pile-up) with fresh settings.
    if (new_pulse) begin
      amp_d   = amplitude;
      base_d  = baseline;
      rs_d    = rise_shift;
      coef_d  = decay_coef;
      per_d   = period;
      state_d = RISE;
      ridx_d  = '0;
      env_d   = sat_add(env_q, amplitude >>> rise_shift);
      tdata_d = sat_add(baseline, env_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      env_q   <= '0;
      tdata_q <= '0;
      cnt_q   <= '0;
      ridx_q  <= '0;
      amp_q   <= '0;
      base_q  <= '0;
      rs_q    <= '0;
      coef_q  <= '0;
      per_q   <= '0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      tdata_q <= tdata_d;
      cnt_q   <= cnt_d;
      ridx_q  <= ridx_d;
      amp_q   <= amp_d;
      base_q  <= base_d;
      rs_q    <= rs_d;
      coef_q  <= coef_d;
      per_q   <= per_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = (state_q != IDLE);
  assign busy          = (state_q != IDLE);
  assign pulse_start   = m_axis_tvalid && (cnt_q == '0);

endmodule

// File: tb/tb_exp_pulse_gen.sv
// Directed bench for exp_pulse_gen: waveform, backpressure, reset, stop,
// saturation and shadow-register behaviour against hand-computed samples.
module tb_exp_pulse_gen;

  logic               clk;
  logic               aresetn;
  logic               enable;
  logic signed [15:0] amplitude;
  logic signed [15:0] baseline;
  logic [3:0]         rise_shift;
  logic [15:0]        decay_coef;
  logic [29:0]        period;
  logic signed [15:0] m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic               pulse_start;
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;

  exp_pulse_gen #(.AXIS_TDATA_WIDTH(16), .COEF_FRAC(16)) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .enable       (enable),
    .amplitude    (amplitude),
    .baseline     (baseline),
    .rise_shift   (rise_shift),
    .decay_coef   (decay_coef),
    .period       (period),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .pulse_start  (pulse_start),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".tvalid"}, int'(m_axis_tvalid), 0);
    check_eq({tag, ".tdata"},  int'(m_axis_tdata),  0);
    check_eq({tag, ".pstart"}, int'(pulse_start),   0);
    check_eq({tag, ".busy"},   int'(busy),          0);
  endtask

  task automatic set_params(input int amp, input int base, input int rs,
                            input int coef, input int per);
    amplitude  = 16'(amp);
    baseline   = 16'(base);
    rise_shift = 4'(rs);
    decay_coef = 16'(coef);
    period     = 30'(per);
  endtask

  // Pulse A: step 256 over 4 samples, halve per sample, restart every 8.
  int wave_a[13] = '{256, 512, 768, 1024, 512, 256, 128, 64,
                     320, 576, 832, 1088, 544};
  // Pulse B: amplitude changed to 2048 mid-decay; second pulse steps by 512.
  int wave_b[13] = '{256, 512, 768, 1024, 512, 256, 128, 64,
                     576, 1088, 1600, 2112, 1056};

  initial begin
    aresetn       = 1'b0;
    enable        = 1'b0;
    m_axis_tready = 1'b1;
    set_params(0, 0, 0, 0, 0);
    tick();
    tick();
    check_idle("reset0");

    aresetn = 1'b1;
    set_params(1024, 0, 2, 'h8000, 8);
    tick();
    check_idle("idle_no_enable");

    // Waveform with periodic retrigger and pile-up.
    enable = 1'b1;
    tick();
    for (int i = 0; i < 13; i++) begin
      check_eq($sformatf("wave[%0d].tdata", i), int'(m_axis_tdata), wave_a[i]);
      check_eq($sformatf("wave[%0d].pstart", i), int'(pulse_start),
               (i == 0 || i == 8) ? 1 : 0);
      check_eq($sformatf("wave[%0d].tvalid", i), int'(m_axis_tvalid), 1);
      tick();
    end

    // Reset held 4 cycles mid-pulse, enable still high.
    aresetn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_idle($sformatf("rst_mid[%0d]", i));
    end

    // Backpressure while presenting 512.
    aresetn = 1'b1;
    tick();
    check_eq("bp.first", int'(m_axis_tdata), 256);
    tick();
    check_eq("bp.pre", int'(m_axis_tdata), 512);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("bp.hold[%0d].tdata", i), int'(m_axis_tdata), 512);
      check_eq($sformatf("bp.hold[%0d].tvalid", i), int'(m_axis_tvalid), 1);
    end
    m_axis_tready = 1'b1;
    tick();
    check_eq("bp.after", int'(m_axis_tdata), 768);

    // Stop requested during a stall.
    m_axis_tready = 1'b0;
    enable        = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq($sformatf("stop.hold[%0d].tvalid", i), int'(m_axis_tvalid), 1);
      check_eq($sformatf("stop.hold[%0d].tdata", i), int'(m_axis_tdata), 768);
      check_eq($sformatf("stop.hold[%0d].busy", i), int'(busy), 1);
    end
    m_axis_tready = 1'b1;
    tick();
    check_idle("stop.done");

    // Positive and negative saturation, one-shot mode.
    set_params(2000, 32000, 0, 'hFFFF, 0);
    enable = 1'b1;
    tick();
    check_eq("sat.pos0", int'(m_axis_tdata), 32767);
    check_eq("sat.pos0.pstart", int'(pulse_start), 1);
    tick();
    check_eq("sat.pos1", int'(m_axis_tdata), 32767);
    check_eq("sat.pos1.pstart", int'(pulse_start), 0);
    enable = 1'b0;
    tick();
    check_idle("sat.stop");
    set_params(-2000, -32000, 0, 'hFFFF, 0);
    enable = 1'b1;
    tick();
    check_eq("sat.neg0", int'(m_axis_tdata), -32768);
    tick();
    check_eq("sat.neg1", int'(m_axis_tdata), -32768);
    enable = 1'b0;
    tick();
    check_idle("sat.stop2");

    // Shadowing: amplitude change mid-decay only affects the next pulse.
    set_params(1024, 0, 2, 'h8000, 8);
    enable = 1'b1;
    tick();
    for (int i = 0; i < 13; i++) begin
      check_eq($sformatf("shadow[%0d].tdata", i), int'(m_axis_tdata), wave_b[i]);
      check_eq($sformatf("shadow[%0d].pstart", i), int'(pulse_start),
               (i == 0 || i == 8) ? 1 : 0);
      if (i == 4) amplitude = 16'sd2048;
      tick();
    end

    enable = 1'b0;
    tick();
    check_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exp_pulse_gen.md
EXP_PULSE_GEN -- requirements
Module: exp_pulse_gen

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 16, sample width (all data ports below assume 16).
REQ-002 SHALL have parameter COEF_FRAC, default 16, fraction bits of decay_coef.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 aresetn  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  run request; generator streams while high.
REQ-006 amplitude  input  16 signed  pulse height above baseline; negative allowed.
REQ-007 baseline  input  16 signed  DC offset added to every sample.
REQ-008 rise_shift  input  4  rise length = 2^rise_shift samples (1..32768).
REQ-009 decay_coef  input  16 unsigned  per-sample decay factor, Q0.16 (0x8000 = 0.5).
REQ-010 period  input  30 unsigned  samples between pulse starts; 0 = one-shot.
REQ-011 m_axis_tdata  output  16 signed  sample.
REQ-012 m_axis_tvalid  output  1  sample valid.
REQ-013 m_axis_tready  input  1  downstream ready.
REQ-014 pulse_start  output  1  high while presented sample is sample 0 of a pulse.
REQ-015 busy  output  1  high when state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, RISE, DECAY; transfer = tvalid and tready in the same cycle.
REQ-017 IDLE: tvalid=0, env=0, count=0; enable=1 -> RISE next cycle, presenting sample 0 (latency 1 cycle).
REQ-018 At each pulse start SHALL latch amplitude, baseline, rise_shift, decay_coef, period into shadow registers; mid-pulse input changes take effect only at the next pulse start.
REQ-019 step = amplitude >>> rise_shift (arithmetic shift, shadow values).
REQ-020 RISE sample update: env = sat16(env + step); after 2^rise_shift RISE samples -> DECAY.
REQ-021 DECAY sample update: env = (env * decay_coef) >>> COEF_FRAC, 17x17 signed product (coef zero-extended), arithmetic shift (floor).
REQ-022 Presented sample SHALL be tdata = sat16(baseline + env_n), env_n being env after update n; saturation clamps to 32767/-32768.
REQ-023 State, env, count and tdata SHALL advance only on a transfer; with tready=0 all outputs hold stable.
REQ-024 count increments per transfer; after the transfer of count = period-1, next sample is count 0 and a new pulse starts in RISE from the current env (pile-up, no env clear).
REQ-025 period=1: every sample is a pulse start (permanent RISE); period=0: count never wraps, single pulse, DECAY persists until enable low.
REQ-026 enable low with tvalid=1: tvalid SHALL remain high until the pending transfer, then next cycle IDLE (tvalid=0).
REQ-027 enable low with tvalid=0: IDLE next cycle; enable re-assert always restarts at sample 0 with env=0.
REQ-028 pulse_start=1 exactly while tvalid=1 and presented count=0; busy=0 only in IDLE.

Reset
REQ-029 aresetn=0 at any clock edge, including mid-pulse or mid-stall: next cycle state IDLE, tvalid=0, tdata=0, pulse_start=0, busy=0, env=0, count=0, shadows=0.
REQ-030 First sample after reset release needs enable=1 sampled with aresetn=1; no partial-pulse continuation.

Verification
REQ-031 Reset: aresetn=0 4 cycles mid-pulse -> tvalid=0, tdata=0, pulse_start=0, busy=0 from cycle after first low edge.
REQ-032 Waveform: baseline=0, amplitude=1024, rise_shift=2, decay_coef=0x8000, period=8, tready=1 -> 256,512,768,1024,512,256,128,64,320(pulse_start=1),576,...
REQ-033 Backpressure: case REQ-032, tready=0 for 3 cycles while presenting 512 -> tdata=512, tvalid=1 held 3 cycles, then 768 follows.
REQ-034 Saturation: baseline=32000, amplitude=2000, rise_shift=0, decay_coef=0xFFFF -> first sample 32767; amplitude=-2000, baseline=-32000 -> -32768.
REQ-035 Stop under stall: enable=0 while tvalid=1, tready=0 -> tvalid held until tready=1 transfer, then 0 and busy=0 next cycle.
REQ-036 Shadowing: change amplitude 1024->2048 during DECAY, period=8 -> current pulse unchanged; next pulse step=512.
